// File: rtl/alu32_result_stage.sv
// alu32_result_stage: registered output stage behind the ALU32 logic units.
// Captures result + op tag, derives Zero/Neg flags at capture time, and
// presents them through a valid/ready handshake. A 2-entry skid buffer keeps
// In_Ready flop-driven so consumer backpressure never reaches the ALU
// combinationally.
// Optional feature: define ALU32_RESULT_PARITY_EN to add Out_Par (XOR
// reduction of Out_Data, stored per entry).
module alu32_result_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Flush,
    input  logic [WIDTH-1:0] In_Data,
    input  logic [TAG_W-1:0] In_Tag,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic [TAG_W-1:0] Out_Tag,
    output logic             Out_Zero,
    output logic             Out_Neg,
`ifdef ALU32_RESULT_PARITY_EN
    output logic             Out_Par,
`endif
    output logic             Out_Valid,
    input  logic             Out_Ready
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    // {zero, neg} for a captured word
    function automatic logic [1:0] calc_flags(input logic [WIDTH-1:0] d);
        return {~|d, d[WIDTH-1]};
    endfunction

    // even parity of a captured word
    function automatic logic calc_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic [1:0] state_q;
    logic [1:0] state_d;

    logic             accept;
    logic             fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // skid entry (older-than-nothing, waits behind main)
    logic [WIDTH-1:0] skid_data_p0;
    logic [TAG_W-1:0] skid_tag_p0;
    logic [1:0]       skid_flags_p0;
    // main entry (presented to the consumer)
    logic [WIDTH-1:0] main_data_p1;
    logic [TAG_W-1:0] main_tag_p1;
    logic [1:0]       main_flags_p1;
`ifdef ALU32_RESULT_PARITY_EN
    logic             skid_par_p0;
    logic             main_par_p1;
`endif

    assign In_Ready  = (state_q != TWO);
    assign Out_Valid = (state_q != EMPTY);
    assign accept    = In_Valid & In_Ready;
    assign fire      = Out_Valid & Out_Ready;

    assign Out_Data  = main_data_p1;
    assign Out_Tag   = main_tag_p1;
    assign Out_Zero  = main_flags_p1[1];
    assign Out_Neg   = main_flags_p1[0];
`ifdef ALU32_RESULT_PARITY_EN
    assign Out_Par   = main_par_p1;
`endif

    // next-state and entry-load decode; Flush overrides everything
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = TWO;
                    end else if (fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (fire) begin
                        load_main_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // control state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // ---- stage p0: skid capture from the input ----
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            skid_data_p0  <= '0;
            skid_tag_p0   <= '0;
            skid_flags_p0 <= '0;
`ifdef ALU32_RESULT_PARITY_EN
            skid_par_p0   <= 1'b0;
`endif
        end else if (load_skid) begin
            skid_data_p0  <= In_Data;
            skid_tag_p0   <= In_Tag;
            skid_flags_p0 <= calc_flags(In_Data);
`ifdef ALU32_RESULT_PARITY_EN
            skid_par_p0   <= calc_par(In_Data);
`endif
        end
    end

    // ---- stage p1: main entry, loaded from input or promoted from skid ----
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            main_data_p1  <= '0;
            main_tag_p1   <= '0;
            main_flags_p1 <= '0;
`ifdef ALU32_RESULT_PARITY_EN
            main_par_p1   <= 1'b0;
`endif
        end else if (load_main_in) begin
            main_data_p1  <= In_Data;
            main_tag_p1   <= In_Tag;
            main_flags_p1 <= calc_flags(In_Data);
`ifdef ALU32_RESULT_PARITY_EN
            main_par_p1   <= calc_par(In_Data);
`endif
        end else if (load_main_skid) begin
            main_data_p1  <= skid_data_p0;
            main_tag_p1   <= skid_tag_p0;
            main_flags_p1 <= skid_flags_p0;
`ifdef ALU32_RESULT_PARITY_EN
            main_par_p1   <= skid_par_p0;
`endif
        end
    end

endmodule

// File: tb/tb_alu32_result_stage.sv
// Directed testbench for alu32_result_stage.
module tb_alu32_result_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Flush;
    logic [31:0] In_Data;
    logic [3:0]  In_Tag;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] Out_Data;
    logic [3:0]  Out_Tag;
    logic        Out_Zero;
    logic        Out_Neg;
    logic        Out_Valid;
    logic        Out_Ready;
`ifdef ALU32_RESULT_PARITY_EN
    logic        Out_Par;
`endif

    int checks = 0;
    int errors = 0;

    alu32_result_stage #(.WIDTH(32), .TAG_W(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .In_Data(In_Data), .In_Tag(In_Tag), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out_Data(Out_Data), .Out_Tag(Out_Tag), .Out_Zero(Out_Zero), .Out_Neg(Out_Neg),
`ifdef ALU32_RESULT_PARITY_EN
        .Out_Par(Out_Par),
`endif
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] t);
        In_Valid = v;
        In_Data  = d;
        In_Tag   = t;
    endtask

    initial begin
        Rst_n = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0);
        tick(); tick();
        // reset state
        chk("rst_in_ready",  {31'b0, In_Ready},  32'd1);
        chk("rst_out_valid", {31'b0, Out_Valid}, 32'd0);
        chk("rst_out_data",  Out_Data,           32'd0);
        chk("rst_out_tag",   {28'b0, Out_Tag},   32'd0);
        chk("rst_zero",      {31'b0, Out_Zero},  32'd0);
        chk("rst_neg",       {31'b0, Out_Neg},   32'd0);
        Rst_n = 1'b1;
        tick();

        // single word, 1-cycle latency
        Out_Ready = 1'b1;
        drive(1'b1, 32'h0000_00F0, 4'd3);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        chk("t1_valid", {31'b0, Out_Valid}, 32'd1);
        chk("t1_data",  Out_Data,           32'h0000_00F0);
        chk("t1_tag",   {28'b0, Out_Tag},   32'd3);
        chk("t1_zero",  {31'b0, Out_Zero},  32'd0);
        chk("t1_neg",   {31'b0, Out_Neg},   32'd0);
        tick();
        chk("t1_empty", {31'b0, Out_Valid}, 32'd0);

        // backpressure fills skid
        Out_Ready = 1'b0;
        drive(1'b1, 32'h8000_0000, 4'd1);
        tick();
        chk("t2_rdy_one", {31'b0, In_Ready}, 32'd1);
        drive(1'b1, 32'h0000_0000, 4'd2);
        tick();
        chk("t2_rdy_two", {31'b0, In_Ready}, 32'd0);
        chk("t2_data0",   Out_Data,          32'h8000_0000);
        chk("t2_neg0",    {31'b0, Out_Neg},  32'd1);
        chk("t2_zero0",   {31'b0, Out_Zero}, 32'd0);
        chk("t2_tag0",    {28'b0, Out_Tag},  32'd1);
        // In_Valid in TWO is not accepted
        drive(1'b1, 32'hDEAD_BEEF, 4'd5);
        tick();
        chk("t2_hold_rdy",  {31'b0, In_Ready}, 32'd0);
        chk("t2_hold_data", Out_Data,          32'h8000_0000);
        drive(1'b0, 32'h0, 4'h0);
        Out_Ready = 1'b1;
        tick();
        chk("t2_data1",  Out_Data,           32'h0000_0000);
        chk("t2_zero1",  {31'b0, Out_Zero},  32'd1);
        chk("t2_neg1",   {31'b0, Out_Neg},   32'd0);
        chk("t2_tag1",   {28'b0, Out_Tag},   32'd2);
        chk("t2_valid1", {31'b0, Out_Valid}, 32'd1);
        chk("t2_rdy1",   {31'b0, In_Ready},  32'd1);
        tick();
        chk("t2_empty", {31'b0, Out_Valid}, 32'd0);
        // Out_Ready while EMPTY is ignored
        tick();
        chk("t2_empty_ign", {31'b0, Out_Valid}, 32'd0);

        // streaming, one per cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i, i[3:0]);
            tick();
            chk("t3_valid", {31'b0, Out_Valid}, 32'd1);
            chk("t3_data",  Out_Data,           i);
            chk("t3_tag",   {28'b0, Out_Tag},   i & 32'hF);
            chk("t3_rdy",   {31'b0, In_Ready},  32'd1);
            chk("t3_zero",  {31'b0, Out_Zero},  (i == 0) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 32'h0, 4'h0);
        tick();
        chk("t3_empty", {31'b0, Out_Valid}, 32'd0);

        // flush from TWO drops both entries and the same-cycle word
        Out_Ready = 1'b0;
        drive(1'b1, 32'hA1, 4'd1);
        tick();
        drive(1'b1, 32'hA2, 4'd2);
        tick();
        chk("t4_two", {31'b0, In_Ready}, 32'd0);
        Flush = 1'b1;
        drive(1'b1, 32'hA3, 4'd3);
        tick();
        Flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0);
        chk("t4_valid", {31'b0, Out_Valid}, 32'd0);
        chk("t4_rdy",   {31'b0, In_Ready},  32'd1);
        Out_Ready = 1'b1;
        tick();
        chk("t4_still_empty", {31'b0, Out_Valid}, 32'd0);
        drive(1'b1, 32'h55, 4'd7);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        chk("t4_next_data", Out_Data,         32'h55);
        chk("t4_next_tag",  {28'b0, Out_Tag}, 32'd7);
        tick();

        // asynchronous reset mid-cycle while in ONE
        Out_Ready = 1'b0;
        drive(1'b1, 32'h1234_5678, 4'd9);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        chk("t5_pre_data", Out_Data, 32'h1234_5678);
        #2 Rst_n = 1'b0;
        #1;
        chk("t5_valid", {31'b0, Out_Valid}, 32'd0);
        chk("t5_data",  Out_Data,           32'd0);
        chk("t5_tag",   {28'b0, Out_Tag},   32'd0);
        chk("t5_rdy",   {31'b0, In_Ready},  32'd1);
        tick();
        Rst_n = 1'b1;
        Out_Ready = 1'b1;
        drive(1'b1, 32'h0000_000F, 4'd4);
        tick();
        drive(1'b0, 32'h0, 4'h0);
        chk("t5_resume_data",  Out_Data,           32'h0000_000F);
        chk("t5_resume_valid", {31'b0, Out_Valid}, 32'd1);
        tick();

`ifdef ALU32_RESULT_PARITY_EN
        // parity stored with each entry
        drive(1'b1, 32'h0000_0007, 4'd1);
        tick();
        chk("t6_par7", {31'b0, Out_Par}, 32'd1);
        drive(1'b1, 32'h0000_0003, 4'd2);
        tick();
        chk("t6_par3", {31'b0, Out_Par}, 32'd0);
        drive(1'b0, 32'h0, 4'h0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu32_result_stage.md
Name: alu32_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit logic units (And32 and siblings) in ALU32.
- Captures the combinational logic result plus an op tag, derives Zero and Negative flags, and presents them to the consumer through a valid/ready handshake.
- A 2-entry skid buffer lets In_Ready come straight from a flop, so consumer backpressure never forms a combinational path into the ALU.

Parameters:
- WIDTH, 32, data width of the result path.
- TAG_W, 4, width of the opaque op tag carried alongside each result.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Flush  input  1  synchronous clear of all buffered entries.
- In_Data  input  WIDTH  result from the logic unit (e.g. And32 Out).
- In_Tag  input  TAG_W  op tag accompanying In_Data.
- In_Valid  input  1  upstream has a result this cycle.
- In_Ready  output  1  stage can accept; driven directly from state flops.
- Out_Data  output  WIDTH  buffered result.
- Out_Tag  output  TAG_W  buffered tag.
- Out_Zero  output  1  1 when Out_Data == 0.
- Out_Neg  output  1  Out_Data[WIDTH-1].
- Out_Valid  output  1  Out_* fields hold a valid entry.
- Out_Ready  input  1  consumer accepts this cycle.

Behaviour:
- Clocking and reset:
  - One clock, Clk.
  - Reset is asynchronous and active-low on Rst_n.
  - During and after reset: state EMPTY, In_Ready=1, Out_Valid=0, Out_Data=0, Out_Tag=0, Out_Zero=0, Out_Neg=0, skid register=0.
- Handshake:
  - Accept = In_Valid & In_Ready.
  - Fire = Out_Valid & Out_Ready.
  - Upstream holds In_* stable while In_Valid=1 and In_Ready=0.
  - Out_* hold stable while Out_Valid=1 and Out_Ready=0.
- Flags:
  - Computed from the incoming word at capture time and stored with it.
  - Zero = ~|data; Neg = data[WIDTH-1].
  - Flags move with their entry from skid to main.
- State machine (state is registered):
  - EMPTY: Accept → main<=In, go to ONE.
  - ONE, Accept & Fire → main<=In, stay in ONE.
  - ONE, Accept & ~Fire → skid<=In, go to TWO.
  - ONE, ~Accept & Fire → go to EMPTY.
  - ONE, otherwise → hold.
  - TWO: In_Ready=0; Fire → main<=skid, go to ONE; otherwise hold.
- Output decode: In_Ready = (state != TWO); Out_Valid = (state != EMPTY).
- Latency: 1 cycle from Accept to Out_Valid when the stage is empty.
- Throughput: 1 result per cycle with Out_Ready held high.
- Ordering: strict FIFO; the skid entry is never presented before the main entry.
- Flush:
  - Synchronous, highest priority: next state EMPTY, Out_Valid=0, In_Ready=1.
  - Any Accept in the same cycle is dropped.
  - Data registers keep stale contents; consumers ignore them while Out_Valid=0.
- Reset mid-operation: all entries are discarded immediately (asynchronous); no transfer completes in that cycle.
- Boundaries:
  - In_Valid while in TWO is not accepted.
  - Out_Ready while EMPTY is ignored.
  - Fire and Accept in the same cycle while in TWO cannot occur, since In_Ready=0.

Optional Feature:
- Macro: ALU32_RESULT_PARITY_EN.
- When defined:
  - Adds output Out_Par (1 bit) = even parity (XOR reduction) of Out_Data.
  - Computed at capture time and stored per entry like the flags.
  - Reset value 0.
- When undefined: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Reset, then Out_Ready=1 and In=0x0000_00F0/tag 3 with In_Valid for one cycle → next cycle Out_Valid=1, Out_Data=0x0000_00F0, Out_Tag=3, Zero=0, Neg=0; following cycle Out_Valid=0.
- Out_Ready=0, push 0x8000_0000 then 0x0000_0000 on consecutive cycles → In_Ready drops after the second accept; Out shows 0x8000_0000 with Neg=1. Raise Out_Ready → next word 0x0000_0000 with Zero=1, then EMPTY.
- Out_Ready=1 with continuous In_Valid streaming 0,1,2,…,15 → one output per cycle in order, In_Ready never drops, 1-cycle latency.
- In state TWO, assert Flush with In_Valid=1 → next cycle Out_Valid=0, In_Ready=1; flushed and same-cycle words never appear at the output.
- Drop Rst_n asynchronously mid-cycle while in ONE with Out_Data=0x1234_5678 → outputs clear to 0 and In_Ready=1 before the next edge; operation resumes normally after release.
- With ALU32_RESULT_PARITY_EN defined, push 0x0000_0007 → Out_Par=1; push 0x0000_0003 → Out_Par=0.
